ehgu_delay_mem: RTL and testbench
=================================

// Module: ehgu_delay_mem
// PURPOSE
//  Storage and valid-tracking stage downstream of the ehgu FIFO address logic.
//  Consumes waddr/raddr, which move in lockstep with raddr = (waddr - SHIFT) mod DEPTH.
//  Writes one din word per advance and reads the word written SHIFT advances earlier.
//  Net result: a fixed-depth, advance-gated delay line with a qualified output.
//  Single clock domain (wclk); sits between the ingest datapath and the delayed-sample consumer.
// PARAMETERS
//  WIDTH   8    data word width
//  AWIDTH  8    address width; must satisfy 2**AWIDTH >= DEPTH
//  DEPTH   128  number of storage words
//  SHIFT   20   delay in advances; legal range 1..DEPTH-1, elaboration $error otherwise
// PORTS
//  wclk        in   1       clock; all logic on posedge wclk
//  rstn        in   1       reset, asynchronous, active-low
//  advance     in   1       same strobe that steps the address logic
//  flush       in   1       restart fill tracking
//  waddr       in   AWIDTH  write address from address logic
//  raddr       in   AWIDTH  read address from address logic
//  din         in   WIDTH   write data, sampled when advance=1
//  dout        out  WIDTH   delayed data
//  dout_valid  out  1       dout holds a word written exactly SHIFT advances earlier
//  fill_level  out  AWIDTH  accepted writes since reset/flush, saturates at SHIFT
//  primed      out  1       state==PRIMED
//  parity_err  out  1       one-cycle pulse on read parity mismatch (see CONFIGURATION)
// BEHAVIOUR
//  Reset: dout=0, dout_valid=0, fill_level=0, primed=0, parity_err=0, state=FILL.
//   Memory contents are not reset.
//  FSM {FILL, PRIMED}:
//   - FILL -> PRIMED on advance & !flush & fill_level==SHIFT-1.
//   - PRIMED -> FILL on flush.
//   - Reset mid-operation returns to FILL.
//  Write: when advance & !flush, mem[waddr] <= din.
//  Read: registered, 1-cycle latency.
//   - When advance & !flush: dout <= mem[raddr] (old data).
//   - Otherwise dout holds its value.
//  dout_valid (registered) <= advance & !flush & (state==PRIMED).
//   - The first valid word is word 0, presented the cycle after advance #SHIFT+1 (1-based).
//  fill_level: +1 per accepted advance, saturates at SHIFT, cleared to 0 by flush.
//  Simultaneous flush & advance: flush wins.
//   - No write, no read, dout_valid=0, fill_level=0, state=FILL.
//  Address wrap: the block does no modulo arithmetic; waddr/raddr are used as given.
//   - Any address >= DEPTH is ignored for the write and reads as 0.
//  Read/write collision: same address in one cycle is unreachable (SHIFT>=1).
//   - The RAM need not define it.
//  advance=0: every register holds; dout_valid drops to 0 the cycle after.
// CONFIGURATION
//  Macro EHGU_DELAY_PARITY_EN defined:
//   - RAM word is WIDTH+1 bits, storing even parity of din.
//   - On each valid read, parity is recomputed; parity_err pulses 1 cycle,
//     aligned with dout_valid, when it mismatches.
//  Macro undefined:
//   - RAM is WIDTH bits and parity_err is tied 0.
//   - The port is present in both builds.
// STRUCTURE
//  ehgu_pkg holds:
//   - typedef enum logic {FILL, PRIMED} ehgu_delay_state_e
//   - function automatic logic ehgu_even_parity(input logic [WIDTH-1:0] d)
//  Sub-module ehgu_dp_ram:
//   - simple dual-port RAM, one write port and one registered read port,
//     single clock, parameters DW/AW/DEPTH, no reset.
//  Top-level ehgu_delay_mem holds the FSM, fill counter, valid flop and parity check.
// TESTING (WIDTH=8, DEPTH=128, SHIFT=20; address logic instanced in the bench)
//  1. Reset, then advance every cycle with din=k for k=0..59.
//     -> dout_valid first high the cycle after advance #21, with dout=0.
//     -> Thereafter dout=k-20; primed rises after advance #20.
//  2. Pulse advance 1-in-3 for 200 cycles.
//     -> dout_valid only follows an advance, and the delay stays exactly 20 advances.
//     -> dout is stable between advances.
//  3. Run 300 advances so the addresses wrap twice.
//     -> No missing or duplicated words across waddr 127->0 and raddr 127->0.
//  4. After priming, assert flush together with advance.
//     -> Next cycle: fill_level=0, primed=0, dout_valid=0, no write.
//     -> 20 further advances are needed to re-prime.
//  5. Deassert rstn asynchronously mid-stream with advance high.
//     -> All outputs are 0 immediately; after release, behaviour matches scenario 1.
//  6. With EHGU_DELAY_PARITY_EN, force-flip bit 3 of stored word 5.
//     -> parity_err=1 exactly in the cycle dout=5 (corrupted) with dout_valid=1.
//     -> Without the macro, parity_err stays 0.

Source files
------------

// File: rtl/ehgu_pkg.sv
// ehgu_pkg: shared types and helpers for the ehgu delay-line slice.
//   ehgu_delay_state_e : fill-tracking FSM states (FILL, PRIMED)
//   ehgu_even_parity   : even-parity bit of a data word
package ehgu_pkg;

  typedef enum logic {
    FILL   = 1'b0,
    PRIMED = 1'b1
  } ehgu_delay_state_e;

  // Widest word the parity helper accepts; callers zero-extend, which
  // leaves the parity unchanged.
  localparam int unsigned EHGU_PARITY_MAX_W = 64;

  // Returns the bit that makes {bit, d} contain an even number of ones.
  function automatic logic ehgu_even_parity(input logic [EHGU_PARITY_MAX_W-1:0] d);
    return ^d;
  endfunction

endpackage

// File: rtl/ehgu_dp_ram.sv
// ehgu_dp_ram: simple dual-port RAM, single clock, no reset.
//   clk_i            clock
//   we_i/waddr_i/wdata_i  write port; addresses >= DEPTH are dropped
//   re_i/raddr_i     registered read port; addresses >= DEPTH read as 0
//   rdata_o          read data, updated the cycle after re_i, held otherwise
// Same-address read/write in one cycle is left undefined.
module ehgu_dp_ram #(
  parameter int unsigned DW    = 8,
  parameter int unsigned AW    = 8,
  parameter int unsigned DEPTH = 128
) (
  input  logic          clk_i,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [DW-1:0] wdata_i,
  input  logic          re_i,
  input  logic [AW-1:0] raddr_i,
  output logic [DW-1:0] rdata_o
);

  localparam int unsigned IW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] DEPTH_W = (AW+1)'(DEPTH);

  logic [DW-1:0] mem_q [DEPTH];
  logic [DW-1:0] rdata_q;
  logic          wr_in_range;
  logic          rd_in_range;

  // Range check on a one-bit-wider compare so DEPTH == 2**AW still works.
  assign wr_in_range = ({1'b0, waddr_i} < DEPTH_W);
  assign rd_in_range = ({1'b0, raddr_i} < DEPTH_W);

  always_ff @(posedge clk_i) begin
    if (we_i && wr_in_range) begin
      mem_q[waddr_i[IW-1:0]] <= wdata_i;
    end
    if (re_i) begin
      rdata_q <= rd_in_range ? mem_q[raddr_i[IW-1:0]] : '0;
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/ehgu_delay_mem.sv
// ehgu_delay_mem: advance-gated fixed delay line with qualified output.
// Writes din at waddr and reads raddr (= waddr - SHIFT, supplied by the
// address logic) on every advance; dout_valid marks a word written exactly
// SHIFT advances earlier.
//   wclk, rstn   clock, asynchronous active-low reset
//   advance      step strobe shared with the address logic
//   flush        restart fill tracking (wins over advance)
//   waddr/raddr  addresses from the address logic, used as given
//   din          write data
//   dout         delayed data (1-cycle registered read)
//   dout_valid   dout is a fully delayed word
//   fill_level   accepted writes since reset/flush, saturating at SHIFT
//   primed       FSM in PRIMED
//   parity_err   read parity mismatch pulse, aligned with dout_valid
// Build option: define EHGU_DELAY_PARITY_EN to store and check an even
// parity bit per word; otherwise parity_err is tied low.
module ehgu_delay_mem
  import ehgu_pkg::*;
#(
  parameter int unsigned WIDTH  = 8,
  parameter int unsigned AWIDTH = 8,
  parameter int unsigned DEPTH  = 128,
  parameter int unsigned SHIFT  = 20
) (
  input  logic              wclk,
  input  logic              rstn,
  input  logic              advance,
  input  logic              flush,
  input  logic [AWIDTH-1:0] waddr,
  input  logic [AWIDTH-1:0] raddr,
  input  logic [WIDTH-1:0]  din,
  output logic [WIDTH-1:0]  dout,
  output logic              dout_valid,
  output logic [AWIDTH-1:0] fill_level,
  output logic              primed,
  output logic              parity_err
);

  if (SHIFT < 1 || SHIFT >= DEPTH) begin : g_bad_shift
    $error("ehgu_delay_mem: SHIFT must be in 1..DEPTH-1");
  end
  if (AWIDTH < 31 && DEPTH > (32'd1 << AWIDTH)) begin : g_bad_awidth
    $error("ehgu_delay_mem: 2**AWIDTH must cover DEPTH");
  end
  if (WIDTH > EHGU_PARITY_MAX_W) begin : g_bad_width
    $error("ehgu_delay_mem: WIDTH exceeds parity helper width");
  end

  localparam logic [AWIDTH-1:0] SHIFT_W  = AWIDTH'(SHIFT);
  localparam logic [AWIDTH-1:0] SHIFT_M1 = AWIDTH'(SHIFT - 1);

`ifdef EHGU_DELAY_PARITY_EN
  localparam int unsigned DW = WIDTH + 1;
`else
  localparam int unsigned DW = WIDTH;
`endif

  ehgu_delay_state_e state_q;
  logic [AWIDTH-1:0] fill_q;
  logic              valid_q;
  logic              rd_seen_q;
  logic              accept;
  logic [DW-1:0]     wdata;
  logic [DW-1:0]     rdata;

  assign accept = advance & ~flush;

  always_ff @(posedge wclk or negedge rstn) begin
    if (!rstn) begin
      state_q   <= FILL;
      fill_q    <= '0;
      valid_q   <= 1'b0;
      rd_seen_q <= 1'b0;
    end else if (flush) begin
      state_q <= FILL;
      fill_q  <= '0;
      valid_q <= 1'b0;
    end else if (advance) begin
      valid_q   <= (state_q == PRIMED);
      rd_seen_q <= 1'b1;
      if (fill_q != SHIFT_W) begin
        fill_q <= fill_q + AWIDTH'(1);
      end
      if (state_q == FILL && fill_q == SHIFT_M1) begin
        state_q <= PRIMED;
      end
    end else begin
      valid_q <= 1'b0;
    end
  end

  ehgu_dp_ram #(
    .DW   (DW),
    .AW   (AWIDTH),
    .DEPTH(DEPTH)
  ) u_ram (
    .clk_i  (wclk),
    .we_i   (accept),
    .waddr_i(waddr),
    .wdata_i(wdata),
    .re_i   (accept),
    .raddr_i(raddr),
    .rdata_o(rdata)
  );

  // The RAM read register has no reset; dout reads 0 until the first read
  // after reset so the output still comes up cleared (and clears at once
  // on an asynchronous reset).
  assign dout       = rd_seen_q ? rdata[WIDTH-1:0] : '0;
  assign dout_valid = valid_q;
  assign fill_level = fill_q;
  assign primed     = (state_q == PRIMED);

`ifdef EHGU_DELAY_PARITY_EN
  assign wdata      = {ehgu_even_parity(EHGU_PARITY_MAX_W'(din)), din};
  assign parity_err = valid_q &
                      (ehgu_even_parity(EHGU_PARITY_MAX_W'(rdata[WIDTH-1:0])) != rdata[WIDTH]);
`else
  assign wdata      = din;
  assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_ehgu_delay_mem.sv
// tb_ehgu_delay_mem: bench for ehgu_delay_mem with the address logic
// modelled in the bench (waddr steps per accepted advance, raddr trails by
// SHIFT modulo DEPTH). Stimulus records accepted words in a history queue;
// a word is expected SHIFT accepted advances later once SHIFT words have
// been accepted since the last reset/flush.
module tb_ehgu_delay_mem;

  localparam int unsigned WIDTH  = 8;
  localparam int unsigned AWIDTH = 8;
  localparam int unsigned DEPTH  = 128;
  localparam int unsigned SHIFT  = 20;

  typedef struct {
    logic [WIDTH-1:0] data;
    logic             perr;
  } exp_t;

  logic              wclk    = 1'b0;
  logic              rstn    = 1'b0;
  logic              advance = 1'b0;
  logic              flush   = 1'b0;
  logic [WIDTH-1:0]  din     = '0;
  logic [AWIDTH-1:0] waddr;
  logic [AWIDTH-1:0] raddr;
  logic [WIDTH-1:0]  dout;
  logic              dout_valid;
  logic [AWIDTH-1:0] fill_level;
  logic              primed;
  logic              parity_err;

  int unsigned vectors     = 0;
  int unsigned miscompares = 0;

  // reference model state
  exp_t             sb[$];
  logic [WIDTH-1:0] hist[$];
  int unsigned      cnt         = 0;
  logic             exp_valid   = 1'b0;
  logic             hold_ok     = 1'b0;
  logic [WIDTH-1:0] hold_val    = '0;
  int               corrupt_idx = -1;
  logic             mon_en      = 1'b0;
  exp_t             mon_e;

  always #5 wclk = ~wclk;

  // address logic
  logic [AWIDTH-1:0] wa_q;
  always @(posedge wclk or negedge rstn) begin
    if (!rstn) wa_q <= '0;
    else if (advance && !flush) wa_q <= AWIDTH'((int'(wa_q) + 1) % int'(DEPTH));
  end
  assign waddr = wa_q;
  assign raddr = AWIDTH'((int'(wa_q) + int'(DEPTH) - int'(SHIFT)) % int'(DEPTH));

  ehgu_delay_mem #(
    .WIDTH (WIDTH),
    .AWIDTH(AWIDTH),
    .DEPTH (DEPTH),
    .SHIFT (SHIFT)
  ) dut (
    .wclk      (wclk),
    .rstn      (rstn),
    .advance   (advance),
    .flush     (flush),
    .waddr     (waddr),
    .raddr     (raddr),
    .din       (din),
    .dout      (dout),
    .dout_valid(dout_valid),
    .fill_level(fill_level),
    .primed    (primed),
    .parity_err(parity_err)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // model: evaluate the inputs seen at each clock edge
  always @(posedge wclk) begin
    exp_valid = 1'b0;
    if (rstn) begin
      if (flush) begin
        cnt = 0;
      end else if (advance) begin
        hist.push_back(din);
        if (cnt >= SHIFT) begin
          int   idx;
          exp_t e;
          idx    = hist.size() - 1 - int'(SHIFT);
          e.data = hist[idx];
          e.perr = 1'b0;
          if (idx == corrupt_idx) begin
            e.data = e.data ^ 8'h08;
            e.perr = 1'b1;
          end
          sb.push_back(e);
          exp_valid = 1'b1;
          hold_ok   = 1'b1;
          hold_val  = e.data;
        end else begin
          hold_ok = 1'b0;
        end
        cnt++;
      end
    end
  end

  // monitor
  always @(negedge wclk) begin
    if (mon_en && rstn) begin
      check("dout_valid", 32'(dout_valid), 32'(exp_valid));
      check("fill_level", 32'(fill_level), (cnt >= SHIFT) ? SHIFT : cnt);
      check("primed", 32'(primed), 32'(cnt >= SHIFT));
      if (dout_valid) begin
        if (sb.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL sb_underflow: got dout=%0h with valid, expected no output", dout);
        end else begin
          mon_e = sb.pop_front();
          check("dout", 32'(dout), 32'(mon_e.data));
          check("parity_err", 32'(parity_err), 32'(mon_e.perr));
        end
      end else begin
        check("parity_err_idle", 32'(parity_err), 32'd0);
        if (hold_ok) check("dout_hold", 32'(dout), 32'(hold_val));
      end
    end
  end

  task automatic step(input logic a, input logic f, input logic [WIDTH-1:0] d);
    advance = a;
    flush   = f;
    din     = d;
    @(posedge wclk);
    #1;
  endtask

  task automatic model_reset();
    sb.delete();
    cnt       = 0;
    exp_valid = 1'b0;
    hold_ok   = 1'b0;
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_dout"}, 32'(dout), 32'd0);
    check({tag, "_dout_valid"}, 32'(dout_valid), 32'd0);
    check({tag, "_fill_level"}, 32'(fill_level), 32'd0);
    check({tag, "_primed"}, 32'(primed), 32'd0);
    check({tag, "_parity_err"}, 32'(parity_err), 32'd0);
  endtask

  task automatic ramp(input int unsigned n);
    for (int unsigned k = 0; k < n; k++) step(1'b1, 1'b0, WIDTH'(k));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    // reset state
    rstn = 1'b0;
    repeat (2) @(posedge wclk);
    #1;
    check_zero("reset");
    rstn   = 1'b1;
    mon_en = 1'b1;

    // 1: continuous ramp
    ramp(60);
    step(1'b0, 1'b0, '0);
    step(1'b0, 1'b0, '0);

    // 2: advance 1-in-3
    for (int i = 0; i < 200; i++) step((i % 3) == 0, 1'b0, WIDTH'($urandom));

    // 3: address wrap, with occasional gaps
    for (int i = 0; i < 300; i++) step(1'b1, 1'b0, WIDTH'($urandom));
    for (int i = 0; i < 60; i++) step(($urandom_range(0, 3) != 0), 1'b0, WIDTH'($urandom));

    // 4: flush together with advance, then flush alone, then re-prime
    step(1'b1, 1'b1, WIDTH'($urandom));
    for (int i = 0; i < 25; i++) step(1'b1, 1'b0, WIDTH'($urandom));
    step(1'b0, 1'b1, '0);
    for (int i = 0; i < 30; i++) step(1'b1, 1'b0, WIDTH'($urandom));

    // 5: asynchronous reset mid-stream with advance high
    advance = 1'b1;
    flush   = 1'b0;
    din     = WIDTH'($urandom);
    #2;
    rstn = 1'b0;
    model_reset();
    #1;
    check_zero("arst");
    @(posedge wclk);
    #1;
    advance = 1'b0;
    @(posedge wclk);
    #1;
    check_zero("arst_hold");
    rstn = 1'b1;
    ramp(60);
    step(1'b0, 1'b0, '0);

`ifdef EHGU_DELAY_PARITY_EN
    // 6: corrupt bit 3 of the word stored at address 5
    rstn = 1'b0;
    model_reset();
    step(1'b0, 1'b0, '0);
    rstn = 1'b1;
    for (int unsigned k = 0; k < 30; k++) begin
      if (k == 5) corrupt_idx = hist.size();
      step(1'b1, 1'b0, WIDTH'(k));
      if (k == 5) dut.u_ram.mem_q[5] = dut.u_ram.mem_q[5] ^ 9'h008;
    end
`endif

    step(1'b0, 1'b0, '0);
    step(1'b0, 1'b0, '0);
    check("sb_drained", 32'(sb.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
